// File: rtl/fetch_unit.sv
// Instruction fetch unit: byte-loaded program memory, little-endian 32-bit word fetch
// with a valid/ready output stage, aligned redirect and misaligned-redirect fault trap.
module fetch_unit #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [PC_W-1:0] load_addr,
    input  logic [7:0]      load_byte,
    input  logic            run,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            fault,
    output logic [15:0]     fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [7:0]      mem [0:(1<<PC_W)-1];
    logic [31:0]     word;
    logic            handshake;
    logic            do_fetch;
    logic            do_redirect;
    logic            do_flush;

    // NOTE: the memory has no reset so it maps onto plain RAM and keeps the program across rst_n.
    always_ff @(posedge clk) begin
        if (state == IDLE && load_en)
            mem[load_addr] <= load_byte;
    end

    // Byte offsets wrap with pc, so a word straddling the top of memory reads bytes 0.. again.
    assign word = {mem[pc + PC_W'(3)], mem[pc + PC_W'(2)], mem[pc + PC_W'(1)], mem[pc]};
    assign handshake = instr_valid && instr_ready;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        do_fetch    = 1'b0;
        do_redirect = 1'b0;
        do_flush    = 1'b0;
        case (state)
            IDLE: begin
                if (run && !load_en)
                    state_next = FETCH;
            end
            FETCH: begin
                if (!run) begin
                    state_next = IDLE;
                    do_flush   = 1'b1;
                end else if (redirect) begin
                    if (redirect_pc[1:0] == 2'b00) begin
                        do_redirect = 1'b1;
                    end else begin
                        state_next = FAULT;
                        do_flush   = 1'b1;
                    end
                end else if (!instr_valid || instr_ready) begin
                    do_fetch = 1'b1;
                end
            end
            FAULT: begin
                if (!run)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_next;
            fault <= (state_next == FAULT);
            // A word accepted on the same edge as a redirect or stop still counts.
            if (handshake)
                fetch_count <= fetch_count + 16'd1;
            if (do_fetch) begin
                instr       <= word;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + PC_W'(4);
            end else if (do_redirect) begin
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
            end else if (do_flush) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: stimulus queues expected {pc, word} pairs
// from a byte-array memory model; a monitor compares them at every handshake.
module tb_fetch_unit;

    localparam int PC_W = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_en;
    logic [PC_W-1:0] load_addr;
    logic [7:0]      load_byte;
    logic            run;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            fault;
    logic [15:0]     fetch_count;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     word;
    } exp_t;

    exp_t            exp_q[$];
    logic [7:0]      mem_model [0:(1<<PC_W)-1];
    logic [15:0]     exp_count;
    int              checks = 0;
    int              errors = 0;

    fetch_unit #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_byte   (load_byte),
        .run         (run),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
        return {mem_model[a + PC_W'(3)], mem_model[a + PC_W'(2)],
                mem_model[a + PC_W'(1)], mem_model[a]};
    endfunction

    function automatic void push_word(input logic [PC_W-1:0] a);
        exp_t e;
        e.pc   = a;
        e.word = word_at(a);
        exp_q.push_back(e);
        exp_count = exp_count + 16'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ready is held/randomized until every queued word has been accepted, then dropped.
    task automatic drain(input bit rnd, input bit noise, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                load_en   = 1'($urandom_range(0, 1));
                load_addr = PC_W'($urandom);
                load_byte = 8'($urandom);
            end
            step();
            c++;
        end
        instr_ready = 1'b0;
        load_en     = 1'b0;
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handshake: got instr_pc 0x%03h, expected no word", instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("hs_pc", 32'(instr_pc), 32'(e.pc));
                check("hs_instr", instr, e.word);
            end
        end
    end

    initial begin
        logic [PC_W-1:0] last;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] addr;
        int              cyc;
        int              n;
        int              need;
        bit              coincide;
        logic [7:0]      prog [0:11];

        prog = '{8'd19, 8'd6, 8'd80, 8'd0, 8'd147, 8'd102, 8'd176, 8'd0,
                 8'd51, 8'd135, 8'd198, 8'd0};
        rst_n = 1'b1; load_en = 1'b0; load_addr = '0; load_byte = '0; run = 1'b0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0; exp_count = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", 32'(instr_pc), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        step();
        rst_n = 1'b1;

        for (int a = 0; a < (1 << PC_W); a++) begin
            load_en   = 1'b1;
            load_addr = PC_W'(a);
            load_byte = (a < 12) ? prog[a] : 8'($urandom);
            mem_model[a] = load_byte;
            step();
        end
        load_en = 1'b0;

        // Program stream at full rate: one idle->fetch edge, one fill edge, three handshakes.
        push_word(PC_W'(0)); push_word(PC_W'(4)); push_word(PC_W'(8));
        run = 1'b1; instr_ready = 1'b1; cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        instr_ready = 1'b0;
        check("stream_cycles", cyc, 5);
        check("stream_count", 32'(fetch_count), 32'd3);
        check("stream_next_pc", 32'(instr_pc), 32'd12);
        run = 1'b0;
        step();
        check("stop_valid", 32'(instr_valid), 32'h0);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_count = '0;

        // Stall with instr_pc=4 pending.
        run = 1'b1;
        push_word(PC_W'(0)); push_word(PC_W'(4)); push_word(PC_W'(8));
        step(); step();
        check("first_valid", 32'(instr_valid), 32'h1);
        check("first_pc", 32'(instr_pc), 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(instr_pc), 32'd4);
            check("stall_instr", instr, 32'h00B06693);
            check("stall_count", 32'(fetch_count), 32'd1);
        end
        drain(1'b1, 1'b0, 50);

        // Redirect to 0, then to 8 while pc 0 is pending and not accepted.
        redirect = 1'b1; redirect_pc = PC_W'(0);
        step();
        redirect = 1'b0;
        check("redir0_flush", 32'(instr_valid), 32'h0);
        step();
        check("redir0_pc", 32'(instr_pc), 32'h0);
        redirect = 1'b1; redirect_pc = PC_W'(8);
        step();
        redirect = 1'b0;
        check("redir8_flush", 32'(instr_valid), 32'h0);
        step();
        check("redir8_pc", 32'(instr_pc), 32'd8);
        check("redir8_instr", instr, 32'h00C68733);
        push_word(PC_W'(8));
        drain(1'b1, 1'b0, 50);
        last = PC_W'(8);

        // Random aligned redirects, some coincident with a handshake, with ignored loads.
        for (int it = 0; it < 8; it++) begin
            target   = PC_W'($urandom_range(0, (1 << PC_W) / 4 - 1) * 4);
            coincide = 1'($urandom_range(0, 1));
            if (coincide) push_word(last + PC_W'(4));
            instr_ready = coincide;
            redirect    = 1'b1;
            redirect_pc = target;
            step();
            redirect    = 1'b0;
            instr_ready = 1'b0;
            n    = $urandom_range(1, 24);
            addr = target;
            for (int k = 0; k < n; k++) begin
                push_word(addr);
                addr = addr + PC_W'(4);
            end
            drain(1'b1, 1'b1, 4 * n + 40);
            last = addr - PC_W'(4);
            check("rand_count", 32'(fetch_count), 32'(exp_count));
        end

        // Misaligned redirect traps; redirect ignored in the trap; pc survives.
        redirect = 1'b1; redirect_pc = PC_W'(6);
        step();
        check("fault_set", 32'(fault), 32'h1);
        check("fault_valid", 32'(instr_valid), 32'h0);
        redirect_pc = PC_W'(0);
        step();
        redirect = 1'b0;
        check("fault_hold", 32'(fault), 32'h1);
        check("fault_hold_valid", 32'(instr_valid), 32'h0);
        run = 1'b0;
        step();
        check("fault_clear", 32'(fault), 32'h0);
        run = 1'b1;
        push_word(last + PC_W'(8));
        drain(1'b1, 1'b0, 50);
        last = last + PC_W'(8);

        // Wrap past the top of memory and run fetch_count through 0xFFFF to 0.
        redirect = 1'b1; redirect_pc = PC_W'(4092);
        step();
        redirect = 1'b0;
        need = 65535 - int'(exp_count);
        addr = PC_W'(4092);
        for (int k = 0; k < need; k++) begin
            push_word(addr);
            addr = addr + PC_W'(4);
        end
        drain(1'b0, 1'b0, need + 20);
        check("count_ffff", 32'(fetch_count), 32'h0000FFFF);
        push_word(addr);
        drain(1'b0, 1'b0, 10);
        check("count_wrap", 32'(fetch_count), 32'h0);
        check("wrap_fault", 32'(fault), 32'h0);

        // Asynchronous reset with a word pending; memory must survive.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc", 32'(instr_pc), 32'h0);
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_fault", 32'(fault), 32'h0);
        check("mid_rst_count", 32'(fetch_count), 32'h0);
        step();
        rst_n = 1'b1;
        exp_count = '0;
        for (int k = 0; k < 4; k++) push_word(PC_W'(4 * k));
        drain(1'b1, 1'b0, 60);
        check("post_rst_count", 32'(fetch_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-002 Parameter PC_W SHALL have default 12 and set the byte-address width; memory depth is 2**PC_W bytes.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 load_en  in  1  program-load byte write strobe.
REQ-006 load_addr  in  PC_W  program-load byte address.
REQ-007 load_byte  in  8  program-load data.
REQ-008 run  in  1  fetch enable.
REQ-009 redirect  in  1  branch/jump redirect strobe.
REQ-010 redirect_pc  in  PC_W  redirect target byte address.
REQ-011 instr  out  32  fetched instruction word.
REQ-012 instr_pc  out  PC_W  byte address of instr.
REQ-013 instr_valid  out  1  instr/instr_pc hold a valid word.
REQ-014 instr_ready  in  1  downstream datapath accepts the word.
REQ-015 fault  out  1  misaligned redirect detected.
REQ-016 fetch_count  out  16  count of accepted words.

Function
REQ-017 The block SHALL hold a byte-wide instruction memory of 2**PC_W entries, written only on clk with load_en=1 in IDLE, at mem[load_addr] <= load_byte.
REQ-018 The block SHALL assemble each word little-endian: instr = {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}.
REQ-019 The block SHALL implement three states: IDLE, FETCH, FAULT.
REQ-020 IDLE: instr_valid=0; the block SHALL go to FETCH when run=1 and load_en=0; otherwise it stays in IDLE.
REQ-021 FETCH: when instr_valid=0, or instr_valid=1 and instr_ready=1, the block SHALL load instr from pc, set instr_pc<=pc and instr_valid<=1, and set pc<=pc+4.
REQ-022 Fetch latency SHALL be one cycle: the word at pc is visible on the edge after it is fetched, and sustained throughput is one word per cycle while instr_ready=1.
REQ-023 When instr_valid=1 and instr_ready=0, instr, instr_pc, instr_valid and pc SHALL hold unchanged.
REQ-024 A handshake is instr_valid=1 and instr_ready=1 on one edge; fetch_count SHALL increment by 1 on each handshake and wrap from 0xFFFF to 0.
REQ-025 pc SHALL wrap modulo 2**PC_W: after 4092 the next fetch address is 0 for PC_W=12.
REQ-026 Redirect in FETCH SHALL take priority over fetch and stall.
REQ-027 An aligned redirect (redirect_pc[1:0]=0) SHALL set pc<=redirect_pc and instr_valid<=0, so the pending word is flushed and the target word appears two edges after redirect.
REQ-028 A misaligned redirect SHALL move to FAULT and set fault<=1 and instr_valid<=0; pc SHALL be unchanged.
REQ-029 A handshake coincident with a redirect SHALL still increment fetch_count.
REQ-030 FAULT: the block SHALL hold fault=1 and instr_valid=0 and ignore redirect; when run=0 it goes to IDLE and clears fault.
REQ-031 run=0 in FETCH SHALL move to IDLE and clear instr_valid at the next edge, discarding any unaccepted word; pc is retained.
REQ-032 load_en outside IDLE SHALL be ignored.
REQ-033 Addresses SHALL use only aligned 32-bit words; there is no partial-word fetch.

Reset
REQ-034 While rst_n=0 the block SHALL force state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, fault=0 and fetch_count=0, asynchronously.
REQ-035 Reset SHALL NOT alter memory contents; a reset mid-fetch SHALL drop the in-flight word, and fetching restarts from address 0.

Verification
REQ-036 Load bytes 0..11 = 19,6,80,0, 147,102,176,0, 51,135,198,0, then run=1 with ready=1 -> instr = 0x00500613, 0x00B06693, 0x00C68733 on consecutive cycles; instr_pc = 0, 4, 8; fetch_count = 3.
REQ-037 Hold ready=0 for 3 cycles while instr_pc=4 -> instr stays 0x00B06693 and fetch_count is unchanged; raise ready -> next word is instr_pc=8.
REQ-038 Redirect to 8 while instr_pc=0 is valid and ready=0 -> instr_valid=0 on the next edge, then instr_pc=8 with instr 0x00C68733.
REQ-039 Redirect to 6 -> fault=1 and instr_valid=0; redirect to 0 is ignored; run=0 -> IDLE with fault=0.
REQ-040 Redirect to 4092 with ready=1 -> instr_pc=4092, then 0; fetch_count after 0xFFFF handshakes, plus one more, is 0.
REQ-041 Assert rst_n=0 mid-stream with instr_valid=1 -> all outputs 0 immediately; after release with run=1 the first instr_pc is 0 and memory bytes are intact.
